ctrl_fsm_mc: RTL

//  Multi-cycle CPU control sequencer; successor to the current translation+FSM controller.

---
 rtl/ctrl_fsm_mc_pkg.sv | 37 +++
 rtl/ctrl_fsm_mc_cond.sv | 37 +++
 rtl/ctrl_fsm_mc.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_fsm_mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, ARM condition codes, trap codes.
package ctrl_fsm_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_MEM    = 4'd5,
        S_BRANCH = 4'd6,
        S_UND    = 4'd7,
        S_ABT    = 4'd8
    } state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] TRAP_NONE = 2'b00;
    localparam logic [1:0] TRAP_UND  = 2'b01;
    localparam logic [1:0] TRAP_ABT  = 2'b10;

endpackage

// File: rtl/ctrl_fsm_mc_cond.sv
// Combinational ARM condition-code evaluator: decides whether an instruction executes given {N,Z,C,V}.
module cond_check
    import ctrl_fsm_mc_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/writeback with condition gating,
// a req/ack memory state with timeout abort, a branch state and sticky trap states.
module ctrl_fsm_mc
    import ctrl_fsm_mc_pkg::*;
#(
    parameter int ALU_OPW     = 4,
    parameter int SHIFT_OPW   = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int COND_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 W_IR_valid,
    input  logic [3:0]           cond,
    input  logic [3:0]           NZCV,
    input  logic                 Und_Ins,
    input  logic                 is_ldr,
    input  logic                 is_str,
    input  logic                 is_b,
    input  logic                 rm_imm_s,
    input  logic [1:0]           rs_imm_s,
    input  logic [SHIFT_OPW-1:0] SHIFT_OP,
    input  logic [ALU_OPW-1:0]   ALU_OP,
    input  logic                 S,
    input  logic                 TTCC,
    input  logic                 mem_ack,
    output logic                 write_pc,
    output logic                 write_ir,
    output logic                 write_reg,
    output logic                 LA,
    output logic                 LB,
    output logic                 LC,
    output logic                 LF,
    output logic                 pc_sel_b,
    output logic                 wb_sel_mem,
    output logic                 S_ctrl,
    output logic                 rm_imm_s_ctrl,
    output logic [1:0]           rs_imm_s_ctrl,
    output logic [SHIFT_OPW-1:0] Shift_OP_ctrl,
    output logic [ALU_OPW-1:0]   ALU_OP_ctrl,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 trap,
    output logic [1:0]           trap_code,
    output logic [3:0]           state_dbg
);

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_from_mem;
    logic             w_cond_pass;
    logic             w_pass;

    cond_check u_cond_check (
        .i_cond (cond),
        .i_nzcv (NZCV),
        .o_pass (w_cond_pass)
    );

    assign w_pass = (COND_EN == 0) ? 1'b1 : w_cond_pass;

    // The counter only runs while waiting in S_MEM, so it is zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_from_mem <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_from_mem <= (r_state == S_MEM);
            if (r_state == S_MEM) r_cnt <= r_cnt + 1'b1;
            else                  r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (W_IR_valid) w_next = S_DECODE;
            S_DECODE: begin
                if (Und_Ins)      w_next = S_UND;
                else if (!w_pass) w_next = S_FETCH;
                else if (is_b)    w_next = S_BRANCH;
                else              w_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_ldr || is_str) w_next = S_MEM;
                else if (TTCC)        w_next = S_FETCH;
                else                  w_next = S_WB;
            end
            S_WB:     w_next = S_FETCH;
            // An acknowledge in the final allowed cycle still completes the access.
            S_MEM: begin
                if (mem_ack)               w_next = is_str ? S_FETCH : S_WB;
                else if (r_cnt == CNT_LAST) w_next = S_ABT;
            end
            S_BRANCH: w_next = S_FETCH;
            S_UND:    w_next = S_UND;
            S_ABT:    w_next = S_ABT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        write_pc      = 1'b0;
        write_ir      = 1'b0;
        write_reg     = 1'b0;
        LA            = 1'b0;
        LB            = 1'b0;
        LC            = 1'b0;
        LF            = 1'b0;
        pc_sel_b      = 1'b0;
        wb_sel_mem    = 1'b0;
        S_ctrl        = 1'b0;
        rm_imm_s_ctrl = 1'b0;
        rs_imm_s_ctrl = '0;
        Shift_OP_ctrl = '0;
        ALU_OP_ctrl   = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        trap          = 1'b0;
        trap_code     = TRAP_NONE;
        case (r_state)
            S_FETCH: begin
                write_pc = W_IR_valid;
                write_ir = W_IR_valid;
            end
            S_DECODE: begin
                LA = 1'b1;
                LB = 1'b1;
                LC = 1'b1;
            end
            S_EXEC:   LF = S | TTCC;
            S_WB: begin
                write_reg  = 1'b1;
                wb_sel_mem = r_from_mem;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_str;
            end
            S_BRANCH: begin
                write_pc = 1'b1;
                pc_sel_b = 1'b1;
            end
            S_UND: begin
                trap      = 1'b1;
                trap_code = TRAP_UND;
            end
            S_ABT: begin
                trap      = 1'b1;
                trap_code = TRAP_ABT;
            end
            default: ;
        endcase
        if (r_state == S_EXEC || r_state == S_WB || r_state == S_MEM) begin
            S_ctrl        = S | TTCC;
            rm_imm_s_ctrl = rm_imm_s;
            rs_imm_s_ctrl = rs_imm_s;
            Shift_OP_ctrl = SHIFT_OP;
            ALU_OP_ctrl   = ALU_OP;
        end
    end

    assign state_dbg = r_state;

endmodule
